mc_controller: RTL and testbench

- Multi-cycle main controller for the MIPS subset datapath (addu, subu, ori, lui, lw, sw, beq, jal, jr).
- Sequences a shared-ALU, shared-register-file datapath through FETCH/DECODE/EXEC/MEM/WB states.
- Drives all datapath enables and mux selects from the registered state plus decoded op/funct.
- Waits on a data-memory ready handshake, with a bounded timeout.

---
 rtl/mc_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle main controller for a MIPS-subset datapath
// (addu, subu, ori, lui, lw, sw, beq, jal, jr) built around one shared ALU
// and one shared register file.
//
// The state register steps through FETCH -> DECODE -> EXEC -> MEM -> WB,
// leaving early where an instruction needs fewer steps. Every datapath
// control is a combinational function of the registered state, the IR
// fields op/funct, the ALU zero flag, mem_ready and the MEM wait counter.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op, funct           instr[31:26] and instr[5:0] from the IR
//   zero                ALU equality flag (used by beq)
//   mem_ready           data memory finishes its access this cycle
//   pc_en, ir_en        PC and IR load enables
//   npc_sel             next PC: 00 PC+4, 01 branch, 10 jump, 11 GPR[rs]
//   reg_write           GRF write enable
//   reg_dst             write address: 00 rt, 01 rd, 10 $31
//   mem_to_reg          write data: 00 ALU, 10 memory, 11 PC+4
//   alu_src, ext_op     ALU B source (1 = immediate), 1 = zero-extend
//   alu_op              000 add, 001 sub, 010 or, 011 lui
//   mem_read, mem_write data memory strobes
//   state               current state (FETCH=0 .. WB=4)
//   instr_done          pulse on the final cycle of each instruction
//   illegal             pulse in DECODE for an unsupported op/funct
//   mem_err             pulse when a MEM access times out
module mc_controller #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic [1:0] npc_sel,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src,
    output logic       ext_op,
    output logic [2:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // instruction decode
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_jal, supported;

    assign is_r      = (op == OP_RTYPE);
    assign is_addu   = is_r && (funct == FN_ADDU);
    assign is_subu   = is_r && (funct == FN_SUBU);
    assign is_jr     = is_r && (funct == FN_JR);
    assign is_ori    = (op == OP_ORI);
    assign is_lui    = (op == OP_LUI);
    assign is_lw     = (op == OP_LW);
    assign is_sw     = (op == OP_SW);
    assign is_beq    = (op == OP_BEQ);
    assign is_jal    = (op == OP_JAL);
    assign supported = is_addu | is_subu | is_jr | is_ori | is_lui |
                       is_lw | is_sw | is_beq | is_jal;

    // ALU setup shared by EXEC, MEM and WB so the ALU result stays stable
    // while it is being consumed in the later states.
    logic       x_src, x_ext;
    logic [2:0] x_op;

    always_comb begin
        x_src = is_ori | is_lui | is_lw | is_sw;
        x_ext = is_ori;
        if (is_subu || is_beq) x_op = 3'b001;
        else if (is_ori)       x_op = 3'b010;
        else if (is_lui)       x_op = 3'b011;
        else                   x_op = 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= S_FETCH;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        npc_sel    = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        alu_op     = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        state      = st_q;
        st_d       = S_FETCH;
        cnt_d      = '0;

        case (st_q)
            S_FETCH: begin
                ir_en = 1'b1;
                pc_en = 1'b1;
                st_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b11;
                    pc_en      = 1'b1;
                    npc_sel    = 2'b10;
                    instr_done = 1'b1;
                end else if (is_jr) begin
                    pc_en      = 1'b1;
                    npc_sel    = 2'b11;
                    instr_done = 1'b1;
                end else if (!supported) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    st_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = x_src;
                ext_op  = x_ext;
                alu_op  = x_op;
                if (is_lw || is_sw) begin
                    st_d = S_MEM;
                end else if (is_beq) begin
                    instr_done = 1'b1;
                    if (zero) begin
                        pc_en   = 1'b1;
                        npc_sel = 2'b01;
                    end
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                alu_src = x_src;
                ext_op  = x_ext;
                alu_op  = x_op;
                // ready takes priority over a simultaneous timeout
                if (mem_ready) begin
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    if (is_lw) st_d = S_WB;
                    else       instr_done = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    mem_err    = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    cnt_d     = cnt_q + CNT_ONE;
                    st_d      = S_MEM;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                alu_src    = x_src;
                ext_op     = x_ext;
                alu_op     = x_op;
                reg_dst    = is_r  ? 2'b01 : 2'b00;
                mem_to_reg = is_lw ? 2'b10 : 2'b00;
            end
            default: ;  // stray encodings idle for one cycle, then FETCH
        endcase

        // reset silences the datapath immediately, not at the next edge
        if (reset) begin
            pc_en      = 1'b0;
            ir_en      = 1'b0;
            npc_sel    = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src    = 1'b0;
            ext_op     = 1'b0;
            alu_op     = 3'b000;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            mem_err    = 1'b0;
            state      = 3'd0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. Each stimulus cycle pushes the full
// expected output vector into a scoreboard queue; a monitor pops one entry
// per cycle on the falling edge and compares it with the DUT outputs.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_en, ir_en, reg_write, alu_src, ext_op;
    logic       mem_read, mem_write, instr_done, illegal, mem_err;
    logic [1:0] npc_sel, reg_dst, mem_to_reg;
    logic [2:0] alu_op, state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [21:0] v;
        string       nm;
    } ent_t;
    ent_t sb[$];

    mc_controller #(.WAIT_MAX(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en),
        .npc_sel(npc_sel), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .state(state), .instr_done(instr_done), .illegal(illegal),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {pc_en, ir_en, npc_sel, reg_write, reg_dst, mem_to_reg, alu_src,
    //  ext_op, alu_op, mem_read, mem_write, state, instr_done, illegal, mem_err}
    function automatic logic [21:0] mk(
        input logic pc, input logic ir, input logic [1:0] npc,
        input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
        input logic as, input logic ex, input logic [2:0] aop,
        input logic mr, input logic mw, input logic [2:0] st,
        input logic dn, input logic il, input logic er);
        return {pc, ir, npc, rw, rd, m2r, as, ex, aop, mr, mw, st, dn, il, er};
    endfunction

    logic [21:0] act;
    assign act = {pc_en, ir_en, npc_sel, reg_write, reg_dst, mem_to_reg,
                  alu_src, ext_op, alu_op, mem_read, mem_write, state,
                  instr_done, illegal, mem_err};

    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input logic [21:0] ex,
                       input string nm);
        ent_t e;
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = rdy;
        e.v  = ex;
        e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
                end
            end
        end
    end

    localparam logic [5:0] R0 = 6'b000000, ORI = 6'b001101, LUI = 6'b001111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JAL = 6'b000011, BAD = 6'b111111;
    localparam logic [5:0] SUBU = 6'b100011, ADDU = 6'b100001, JR = 6'b001000;
    localparam logic [5:0] ADD = 6'b100000;

    initial begin : stim
        logic [21:0] v0, vf, vd;
        v0 = mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd0,0,0,0);
        vf = mk(1,1,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd0,0,0,0);
        vd = mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd1,0,0,0);

        cyc(1, ORI, 6'd0, 0, 1, v0, "reset_hold");

        // ori, mem_ready high throughout (ignored outside MEM)
        cyc(0, ORI, 6'd0, 0, 1, vf, "ori_fetch");
        cyc(0, ORI, 6'd0, 0, 1, vd, "ori_decode");
        cyc(0, ORI, 6'd0, 0, 1, mk(0,0,2'b00,0,2'b00,2'b00,1,1,3'b010,0,0,3'd2,0,0,0), "ori_exec");
        cyc(0, ORI, 6'd0, 0, 1, mk(0,0,2'b00,1,2'b00,2'b00,1,1,3'b010,0,0,3'd4,1,0,0), "ori_wb");

        // subu
        cyc(0, R0, SUBU, 0, 0, vf, "subu_fetch");
        cyc(0, R0, SUBU, 0, 0, vd, "subu_decode");
        cyc(0, R0, SUBU, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b001,0,0,3'd2,0,0,0), "subu_exec");
        cyc(0, R0, SUBU, 0, 0, mk(0,0,2'b00,1,2'b01,2'b00,0,0,3'b001,0,0,3'd4,1,0,0), "subu_wb");

        // jr: two cycles
        cyc(0, R0, JR, 0, 0, vf, "jr_fetch");
        cyc(0, R0, JR, 0, 0, mk(1,0,2'b11,0,2'b00,2'b00,0,0,3'b000,0,0,3'd1,1,0,0), "jr_decode");

        // addu
        cyc(0, R0, ADDU, 0, 0, vf, "addu_fetch");
        cyc(0, R0, ADDU, 0, 0, vd, "addu_decode");
        cyc(0, R0, ADDU, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd2,0,0,0), "addu_exec");
        cyc(0, R0, ADDU, 0, 0, mk(0,0,2'b00,1,2'b01,2'b00,0,0,3'b000,0,0,3'd4,1,0,0), "addu_wb");

        // lui
        cyc(0, LUI, 6'd0, 0, 0, vf, "lui_fetch");
        cyc(0, LUI, 6'd0, 0, 0, vd, "lui_decode");
        cyc(0, LUI, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b011,0,0,3'd2,0,0,0), "lui_exec");
        cyc(0, LUI, 6'd0, 0, 0, mk(0,0,2'b00,1,2'b00,2'b00,1,0,3'b011,0,0,3'd4,1,0,0), "lui_wb");

        // beq taken / not taken
        cyc(0, BEQ, 6'd0, 1, 0, vf, "beqt_fetch");
        cyc(0, BEQ, 6'd0, 1, 0, vd, "beqt_decode");
        cyc(0, BEQ, 6'd0, 1, 0, mk(1,0,2'b01,0,2'b00,2'b00,0,0,3'b001,0,0,3'd2,1,0,0), "beqt_exec");
        cyc(0, BEQ, 6'd0, 0, 0, vf, "beqn_fetch");
        cyc(0, BEQ, 6'd0, 0, 0, vd, "beqn_decode");
        cyc(0, BEQ, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b001,0,0,3'd2,1,0,0), "beqn_exec");

        // lw: three wait cycles, ready on the fourth MEM cycle
        cyc(0, LW, 6'd0, 0, 1, vf, "lw_fetch");
        cyc(0, LW, 6'd0, 0, 1, vd, "lw_decode");
        cyc(0, LW, 6'd0, 0, 1, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd2,0,0,0), "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(0, LW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,1,0,3'd3,0,0,0), "lw_mem_wait");
        cyc(0, LW, 6'd0, 0, 1, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,1,0,3'd3,0,0,0), "lw_mem_ready");
        cyc(0, LW, 6'd0, 0, 0, mk(0,0,2'b00,1,2'b00,2'b10,1,0,3'b000,0,0,3'd4,1,0,0), "lw_wb");

        // sw, ready on first MEM cycle
        cyc(0, SW, 6'd0, 0, 0, vf, "sw_fetch");
        cyc(0, SW, 6'd0, 0, 0, vd, "sw_decode");
        cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd2,0,0,0), "sw_exec");
        cyc(0, SW, 6'd0, 0, 1, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,1,3'd3,1,0,0), "sw_mem_ready");

        // sw timeout: 15 waiting cycles, error on the 16th
        cyc(0, SW, 6'd0, 0, 0, vf, "swto_fetch");
        cyc(0, SW, 6'd0, 0, 0, vd, "swto_decode");
        cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd2,0,0,0), "swto_exec");
        for (int i = 0; i < 15; i++)
            cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,1,3'd3,0,0,0), "swto_wait");
        cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd3,1,0,1), "swto_err");
        cyc(0, SW, 6'd0, 0, 0, vf, "swto_after");

        // sw with ready arriving exactly at the timeout count: no error
        cyc(0, SW, 6'd0, 0, 0, vd, "swrt_decode");
        cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd2,0,0,0), "swrt_exec");
        for (int i = 0; i < 15; i++)
            cyc(0, SW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,1,3'd3,0,0,0), "swrt_wait");
        cyc(0, SW, 6'd0, 0, 1, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,1,3'd3,1,0,0), "swrt_ready");

        // jal, then unsupported op and unsupported R funct
        cyc(0, JAL, 6'd0, 0, 0, vf, "jal_fetch");
        cyc(0, JAL, 6'd0, 0, 0, mk(1,0,2'b10,1,2'b10,2'b11,0,0,3'b000,0,0,3'd1,1,0,0), "jal_decode");
        cyc(0, BAD, 6'd0, 0, 0, vf, "ill_fetch");
        cyc(0, BAD, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd1,1,1,0), "ill_decode");
        cyc(0, R0, ADD, 0, 0, vf, "illr_fetch");
        cyc(0, R0, ADD, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0,0,3'd1,1,1,0), "illr_decode");

        // reset asserted while lw waits in MEM
        cyc(0, LW, 6'd0, 0, 0, vf, "rst_fetch");
        cyc(0, LW, 6'd0, 0, 0, vd, "rst_decode");
        cyc(0, LW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,0,0,3'd2,0,0,0), "rst_exec");
        cyc(0, LW, 6'd0, 0, 0, mk(0,0,2'b00,0,2'b00,2'b00,1,0,3'b000,1,0,3'd3,0,0,0), "rst_mem");
        cyc(1, LW, 6'd0, 0, 1, v0, "rst_mid_mem");
        cyc(0, LW, 6'd0, 0, 1, vf, "rst_restart_fetch");
        cyc(0, LW, 6'd0, 0, 1, vd, "rst_restart_decode");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
